// File: rtl/fetch_pkg.sv
// Shared types and instruction constants for the loadable instruction memory / fetch stage.
// Latency: n/a (types only). Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
    localparam logic [31:0] HALT_INSN = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x XLEN instruction store: synchronous write, synchronous registered read (BRAM-inferable).
// Latency: 1 cycle read. Backpressure: none; the read register holds when rd_en_i is low.
module imem_ram #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_dat_i,
    input  logic            rd_en_i,
    input  logic [AW-1:0]   rd_addr_i,
    output logic [XLEN-1:0] rd_dat_o
);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] rd_dat_q;

    // No reset on the array or read register so the tools can map this onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        if (rd_en_i) begin
            rd_dat_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory + fetch stage: LOAD/RUN/HALT FSM, load counter, range/alignment fault decode.
// Latency: fetch result 1 cycle after the fetch edge. Backpressure: stall suppresses a fetch; no output stall.
module instr_fetch_mem
    import fetch_pkg::*;
#(
    parameter int                 XLEN        = 32,
    parameter int                 DEPTH       = 16,
    parameter bit                 BYTE_ADDR   = 1'b1,
    parameter int                 STATE_W     = 4,
    parameter logic [STATE_W-1:0] FETCH_STATE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [STATE_W-1:0]           estado,
    input  logic                         stall,
    input  logic [XLEN-1:0]              pc,
    input  logic                         load_start,
    input  logic                         load_wr,
    input  logic [XLEN-1:0]              load_data,
    input  logic                         load_done,
    output logic [XLEN-1:0]              instrucao,
    output logic                         instr_valid,
    output logic                         fault,
    output logic                         halted,
    output logic [$clog2(DEPTH+1)-1:0]   load_count,
    output logic                         load_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_state_t    state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;
    logic            nop_sel_q, nop_sel_d;

    logic [AW-1:0]   idx;
    logic            misalign;
    logic            upper_nz;
    logic            bad;
    logic            full;
    logic            fetch_req;
    logic            fire;
    logic            halt_hit;
    logic            wr_en;
    logic            rd_en;
    logic [XLEN-1:0] rd_dat;

    // Index field and the bits that must be zero above it depend on the addressing mode.
    if (BYTE_ADDR) begin : g_byte_addr
        assign idx      = pc[AW+1:2];
        assign misalign = |pc[1:0];
        assign upper_nz = |(pc >> (AW + 2));
    end else begin : g_word_addr
        assign idx      = pc[AW-1:0];
        assign misalign = 1'b0;
        assign upper_nz = |(pc >> AW);
    end

    assign full      = (cnt_q == CW'(DEPTH));
    assign bad       = misalign || upper_nz || (CW'(idx) >= cnt_q);
    assign fetch_req = (estado == FETCH_STATE) && !stall;

    // The read data only exists after the fetch edge, so a halt word is recognised in the
    // instr_valid cycle; treating that cycle as HALT already keeps the stage frozen from there.
    assign halt_hit  = (state_q == RUN) && valid_q && !fault_q && (rd_dat == XLEN'(HALT_INSN));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en     = 1'b0;
        fire      = 1'b0;
        if (load_start) begin
            state_d = LOAD;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (load_wr && !full) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (load_done) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (halt_hit) begin
                        state_d = HALT;
                    end else begin
                        fire = fetch_req;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = LOAD;
                end
            endcase
        end
        valid_d   = fire;
        fault_d   = fire ? bad : fault_q;
        nop_sel_d = fire ? bad : nop_sel_q;
        rd_en     = fire && !bad;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            nop_sel_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            nop_sel_q <= nop_sel_d;
        end
    end

    imem_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_imem_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (cnt_q[AW-1:0]),
        .wr_dat_i  (load_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (idx),
        .rd_dat_o  (rd_dat)
    );

    // The RAM register is not reset, so NOP is substituted after reset and after a faulting fetch.
    assign instrucao   = nop_sel_q ? XLEN'(NOP_INSN) : rd_dat;
    assign instr_valid = valid_q;
    assign fault       = fault_q;
    assign halted      = (state_q == HALT) || halt_hit;
    assign load_count  = cnt_q;
    assign load_full   = full;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed, table-driven bench for instr_fetch_mem (DEPTH=16, byte-addressed PC, fetch state 4'b0000).
module tb_instr_fetch_mem;

    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [3:0]  ST_F  = 4'b0000;
    localparam logic [3:0]  ST_X  = 4'b0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  estado;
    logic        stall;
    logic [31:0] pc;
    logic        load_start;
    logic        load_wr;
    logic [31:0] load_data;
    logic        load_done;
    logic [31:0] instrucao;
    logic        instr_valid;
    logic        fault;
    logic        halted;
    logic [4:0]  load_count;
    logic        load_full;

    always #5 clk = ~clk;

    instr_fetch_mem #(
        .XLEN        (32),
        .DEPTH       (DEPTH),
        .BYTE_ADDR   (1'b1),
        .STATE_W     (4),
        .FETCH_STATE (ST_F)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .estado      (estado),
        .stall       (stall),
        .pc          (pc),
        .load_start  (load_start),
        .load_wr     (load_wr),
        .load_data   (load_data),
        .load_done   (load_done),
        .instrucao   (instrucao),
        .instr_valid (instr_valid),
        .fault       (fault),
        .halted      (halted),
        .load_count  (load_count),
        .load_full   (load_full)
    );

    typedef struct {
        logic        ls;
        logic        wr;
        logic [31:0] data;
        logic        done;
        logic        fetch;
        logic        stl;
        logic [31:0] addr;
        logic [31:0] e_instr;
        logic        e_v;
        logic        e_f;
        logic        e_h;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic ls, input logic wr, input logic [31:0] data, input logic done,
                       input logic fetch, input logic stl, input logic [31:0] addr,
                       input logic [31:0] e_instr, input logic e_v, input logic e_f,
                       input logic e_h, input int e_cnt);
        vec_t v;
        v.ls = ls; v.wr = wr; v.data = data; v.done = done;
        v.fetch = fetch; v.stl = stl; v.addr = addr;
        v.e_instr = e_instr; v.e_v = e_v; v.e_f = e_f; v.e_h = e_h; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_instr, input logic e_v,
                           input logic e_f, input logic e_h, input int e_cnt);
        n_vec++;
        chk({tag, " instrucao"},   instrucao, e_instr);
        chk({tag, " instr_valid"}, {31'b0, instr_valid}, {31'b0, e_v});
        chk({tag, " fault"},       {31'b0, fault},       {31'b0, e_f});
        chk({tag, " halted"},      {31'b0, halted},      {31'b0, e_h});
        chk({tag, " load_count"},  {27'b0, load_count},  32'(e_cnt));
        chk({tag, " load_full"},   {31'b0, load_full},   {31'b0, (e_cnt == DEPTH)});
    endtask

    task automatic drive(input logic ls, input logic wr, input logic [31:0] data, input logic done,
                         input logic fetch, input logic stl, input logic [31:0] addr);
        load_start = ls;
        load_wr    = wr;
        load_data  = data;
        load_done  = done;
        estado     = fetch ? ST_F : ST_X;
        stall      = stl;
        pc         = addr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_all("reset", NOP, 0, 0, 0, 0);
        @(negedge clk) rst = 1'b1;

        // Load three words, then fetch them; the third is the halt word
        add(0, 1, 32'h0050_0393, 0, 0, 0, 32'd0,  NOP, 0, 0, 0, 1);
        add(0, 1, 32'hFFF3_8393, 0, 0, 0, 32'd0,  NOP, 0, 0, 0, 2);
        add(0, 1, 32'h0000_0000, 0, 0, 0, 32'd0,  NOP, 0, 0, 0, 3);
        add(0, 0, 32'h0,         1, 0, 0, 32'd0,  NOP, 0, 0, 0, 3);
        add(0, 0, 32'h0,         0, 1, 0, 32'd0,  32'h0050_0393, 1, 0, 0, 3);
        add(0, 0, 32'h0,         0, 1, 0, 32'd4,  32'hFFF3_8393, 1, 0, 0, 3);
        add(0, 0, 32'h0,         0, 0, 0, 32'd4,  32'hFFF3_8393, 0, 0, 0, 3);
        // Faulting fetches: misaligned, unloaded index, beyond DEPTH, high PC bit
        add(0, 0, 32'h0,         0, 1, 0, 32'd2,  NOP, 1, 1, 0, 3);
        add(0, 0, 32'h0,         0, 1, 0, 32'd12, NOP, 1, 1, 0, 3);
        add(0, 0, 32'h0,         0, 1, 0, 32'd64, NOP, 1, 1, 0, 3);
        add(0, 0, 32'h0,         0, 1, 0, 32'h8000_0000, NOP, 1, 1, 0, 3);
        add(0, 0, 32'h0,         0, 0, 0, 32'd0,  NOP, 0, 1, 0, 3);
        add(0, 0, 32'h0,         0, 1, 0, 32'd8,  32'h0, 1, 0, 1, 3);
        add(0, 0, 32'h0,         0, 0, 0, 32'd0,  32'h0, 0, 0, 1, 3);
        add(0, 0, 32'h0,         0, 1, 0, 32'd0,  32'h0, 0, 0, 1, 3);
        add(0, 1, 32'h0000_0123, 0, 0, 0, 32'd0,  32'h0, 0, 0, 1, 3);
        // Overfill: 18 writes, count saturates, fetches during LOAD ignored
        add(1, 0, 32'h0,         0, 0, 0, 32'd0,  32'h0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            add(0, 1, 32'h1000_0000 + 32'(i), 0, 1, 0, 32'd0, 32'h0, 0, 0, 0,
                (i + 1 > DEPTH) ? DEPTH : i + 1);
        end
        add(0, 0, 32'h0,         1, 0, 0, 32'd0,  32'h0, 0, 0, 0, DEPTH);
        add(0, 0, 32'h0,         0, 1, 0, 32'd0,  32'h1000_0000, 1, 0, 0, DEPTH);
        add(0, 0, 32'h0,         0, 1, 0, 32'd60, 32'h1000_000F, 1, 0, 0, DEPTH);
        add(0, 0, 32'h0,         0, 1, 0, 32'd64, NOP, 1, 1, 0, DEPTH);
        // Same-cycle priorities
        add(1, 0, 32'h0,         0, 0, 0, 32'd0,  NOP, 0, 1, 0, 0);
        add(0, 1, 32'hAAAA_0001, 0, 0, 0, 32'd0,  NOP, 0, 1, 0, 1);
        add(0, 1, 32'hAAAA_0002, 0, 0, 0, 32'd0,  NOP, 0, 1, 0, 2);
        add(1, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'd0,  NOP, 0, 1, 0, 0);
        add(0, 1, 32'h00A0_0513, 1, 0, 0, 32'd0,  NOP, 0, 1, 0, 1);
        add(0, 0, 32'h0,         0, 1, 0, 32'd0,  32'h00A0_0513, 1, 0, 0, 1);
        add(0, 0, 32'h0,         0, 1, 0, 32'd4,  NOP, 1, 1, 0, 1);
        add(1, 0, 32'h0,         1, 0, 0, 32'd0,  NOP, 0, 1, 0, 0);
        add(0, 0, 32'h0,         0, 1, 0, 32'd0,  NOP, 0, 1, 0, 0);
        // Stalled fetch requests
        add(0, 1, 32'h0010_8093, 1, 0, 0, 32'd0,  NOP, 0, 1, 0, 1);
        add(0, 0, 32'h0,         0, 1, 0, 32'd0,  32'h0010_8093, 1, 0, 0, 1);
        add(0, 0, 32'h0,         0, 1, 1, 32'd4,  32'h0010_8093, 0, 0, 0, 1);
        add(0, 0, 32'h0,         0, 1, 1, 32'd0,  32'h0010_8093, 0, 0, 0, 1);

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].ls, vecs[k].wr, vecs[k].data, vecs[k].done,
                  vecs[k].fetch, vecs[k].stl, vecs[k].addr);
            @(posedge clk);
            #1 chk_all($sformatf("v%0d", k), vecs[k].e_instr, vecs[k].e_v,
                       vecs[k].e_f, vecs[k].e_h, vecs[k].e_cnt);
        end

        // Reset asserted while a fetch result is being presented
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 1, 0, 32'd0);
        @(posedge clk);
        #1 chk_all("prefetch", 32'h0010_8093, 1, 0, 0, 1);
        rst = 1'b0;
        #1 chk_all("midreset", NOP, 0, 0, 0, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 chk_all("postreset", NOP, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
